instruction_fetch_unit: RTL

//  Consumer and sequencer for program_counter: reads pc_address and drives its next_address input.

---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/instruction_fetch_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants: address/instruction widths, the PC step
// and the {pc, word} record held in the instruction buffer.
package mips_pkg;
  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0]  PC_INCR          = 32'd4;
  localparam logic [ADDR_W-1:0]  DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] INSTR_NOP        = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] word;
  } ibuf_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is readable combinationally and a
// push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: only entries below cnt_q are ever observed.
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: drives the PC, issues in-order imem reads under a credit limit,
// buffers returned words with their PCs and drops stale responses after a redirect.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter int                IBUF_DEPTH   = 4,
  parameter int                MAX_OUTSTAND = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_address,
  output logic [ADDR_W-1:0]  next_address,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst_data,
  output logic [ADDR_W-1:0]  inst_pc
);
  localparam int IBW = $clog2(IBUF_DEPTH + 1);
  localparam int PCW = $clog2(MAX_OUTSTAND + 1);
  localparam int SW  = $clog2(IBUF_DEPTH + MAX_OUTSTAND + 1);

  ibuf_entry_t       ibuf_wr, ibuf_head;
  logic [ADDR_W-1:0] pend_head;
  logic [IBW-1:0]    ibuf_cnt;
  logic [PCW-1:0]    pend_cnt, drop_cnt_q, drop_cnt_d;
  logic [SW-1:0]     live_cnt;
  logic              ibuf_full, ibuf_empty, pend_full, pend_empty;
  logic              credit_ok, req_fire, resp_ok, resp_keep, inst_fire;

  assign imem_req_addr = pc_address;
  assign ibuf_wr       = '{pc: pend_head, word: imem_resp_data};
  assign inst_pc       = ibuf_head.pc;

  always_comb begin
    // Words already in the buffer plus non-stale reads still in flight must fit.
    live_cnt       = SW'(pend_cnt) - SW'(drop_cnt_q) + SW'(ibuf_cnt);
    credit_ok      = ~pend_full & ~ibuf_full & (live_cnt < SW'(IBUF_DEPTH));
    imem_req_valid = reset & ~redirect_valid & credit_ok;
    req_fire       = imem_req_valid & imem_req_ready;
    resp_ok        = reset & imem_resp_valid & ~pend_empty;
    resp_keep      = resp_ok & (drop_cnt_q == '0) & ~redirect_valid;
    inst_valid     = reset & ~ibuf_empty;
    inst_fire      = inst_valid & inst_ready & ~redirect_valid;
    inst_data      = inst_valid ? ibuf_head.word : INSTR_NOP;

    drop_cnt_d = drop_cnt_q;
    if (redirect_valid)                 drop_cnt_d = pend_cnt - PCW'(resp_ok);
    else if (resp_ok && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - PCW'(1);

    if (!reset)              next_address = RESET_VECTOR;
    else if (redirect_valid) next_address = word_align(redirect_target);
    else if (req_fire)       next_address = pc_address + PC_INCR;
    else                     next_address = pc_address;
  end

  always_ff @(posedge clk) begin
    if (!reset) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  always_ff @(posedge clk) begin
    if (reset && imem_resp_valid)
      assert (!pend_empty) else $error("imem response with no pending request");
  end

  fetch_fifo #(.WIDTH($bits(ibuf_entry_t)), .DEPTH(IBUF_DEPTH)) ibuf (
    .clk       (clk),
    .reset     (reset),
    .push      (resp_keep),
    .push_data (ibuf_wr),
    .pop       (inst_fire),
    .flush     (redirect_valid),
    .head_data (ibuf_head),
    .count     (ibuf_cnt),
    .full      (ibuf_full),
    .empty     (ibuf_empty)
  );

  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTSTAND)) pend_q (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (pc_address),
    .pop       (resp_ok),
    .flush     (1'b0),
    .head_data (pend_head),
    .count     (pend_cnt),
    .full      (pend_full),
    .empty     (pend_empty)
  );
endmodule
